// File: rtl/npu_mem_top.sv
// NPU memory subsystem: host LOAD into image/parameter RAMs, RUN byte replay on D_OUT,
// RESW into four result banks. Define STREAM_CKSUM_EN to replay a LOAD-byte checksum after the stream.

module npu_res_bank #(
  parameter int DEPTH = 1984,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i
);
  logic [7:0] mem [DEPTH];

  // NOTE: storage arrays take no reset; clearing them would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= data_i;
  end

  // Contents are observed only through the hierarchy; this tap keeps the array from being write-only.
  logic unused_mem;
  assign unused_mem = ^mem[0];
endmodule

module npu_mem_top #(
  parameter int IMG_WORDS = 224,
  parameter int C12_LEN   = 320,
  parameter int C34_LEN   = 9248,
  parameter int C5_LEN    = 9248,
  parameter int RES_DEPTH = 1984
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic [31:0] control_reg,
  output logic [7:0]  D_OUT
);
  localparam int LD_TOTAL = IMG_WORDS + C12_LEN + C34_LEN + C5_LEN;
  localparam int RD_TOTAL = 4 * IMG_WORDS + C12_LEN + C34_LEN + C5_LEN;
  localparam int PW   = $clog2(RD_TOTAL + 1);
  localparam int QW   = $clog2(RES_DEPTH + 1);
  localparam int IMGW = $clog2(IMG_WORDS);
  localparam int C12W = $clog2(C12_LEN);
  localparam int C34W = $clog2(C34_LEN);
  localparam int C5W  = $clog2(C5_LEN);
  localparam int MAXA = (4 * IMG_WORDS > C12_LEN) ? 4 * IMG_WORDS : C12_LEN;
  localparam int MAXB = (C34_LEN > C5_LEN) ? C34_LEN : C5_LEN;
  localparam int OW   = $clog2((MAXA > MAXB) ? MAXA : MAXB);

  localparam logic [PW-1:0] LD_C12 = PW'(IMG_WORDS);
  localparam logic [PW-1:0] LD_C34 = PW'(IMG_WORDS + C12_LEN);
  localparam logic [PW-1:0] LD_C5  = PW'(IMG_WORDS + C12_LEN + C34_LEN);
  localparam logic [PW-1:0] LD_END = PW'(LD_TOTAL);
  localparam logic [PW-1:0] RD_C12 = PW'(4 * IMG_WORDS);
  localparam logic [PW-1:0] RD_C34 = PW'(4 * IMG_WORDS + C12_LEN);
  localparam logic [PW-1:0] RD_C5  = PW'(4 * IMG_WORDS + C12_LEN + C34_LEN);
  localparam logic [PW-1:0] RD_END = PW'(RD_TOTAL);
  localparam logic [QW-1:0] Q_END  = QW'(RES_DEPTH);

  typedef enum logic [1:0] {MODE_IDLE, MODE_LOAD, MODE_RUN, MODE_RESW} mode_e;
  typedef enum logic [1:0] {RGN_IMG, RGN_C12, RGN_C34, RGN_C5} region_e;
  typedef struct packed {
    region_e       rgn;
    logic [OW-1:0] off;
  } loc_t;

  // Maps a linear load/run pointer onto the RAM it addresses and the offset inside that RAM.
  function automatic loc_t locate(input logic [PW-1:0] ptr, input logic [PW-1:0] b12,
                                  input logic [PW-1:0] b34, input logic [PW-1:0] b5);
    loc_t l;
    if (ptr >= b5) begin
      l.rgn = RGN_C5;  l.off = OW'(ptr - b5);
    end else if (ptr >= b34) begin
      l.rgn = RGN_C34; l.off = OW'(ptr - b34);
    end else if (ptr >= b12) begin
      l.rgn = RGN_C12; l.off = OW'(ptr - b12);
    end else begin
      l.rgn = RGN_IMG; l.off = OW'(ptr);
    end
    return l;
  endfunction

  logic [31:0] img_ram [IMG_WORDS];
  logic [7:0]  c12_ram [C12_LEN];
  logic [7:0]  c34_ram [C34_LEN];
  logic [7:0]  c5_ram  [C5_LEN];

  mode_e         mode_q, mode_d;
  logic [PW-1:0] p_q, p_d, p_eff, r_q, r_d;
  logic [QW-1:0] q_q, q_d, q_eff;
  logic [7:0]    dout_q, dout_d, rd_byte, end_byte;
  logic [31:0]   rd_word;
  logic          load_we, resw_we;
  loc_t          ld_loc, rd_loc;

  logic unused_ctrl;
  assign unused_ctrl = ^control_reg[31:2];

  assign mode_d = mode_e'(control_reg[1:0]);
  assign D_OUT  = dout_q;

  // The pointer of a mode being entered restarts at 0 on the entry edge itself.
  // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    p_eff   = (mode_q == MODE_LOAD) ? p_q : '0;
    q_eff   = (mode_q == MODE_RESW) ? q_q : '0;
    load_we = (mode_d == MODE_LOAD) && (p_eff < LD_END);
    resw_we = (mode_d == MODE_RESW) && (q_eff < Q_END);
    ld_loc  = locate(p_eff, LD_C12, LD_C34, LD_C5);
    p_d     = p_q;
    r_d     = r_q;
    q_d     = q_q;
    dout_d  = dout_q;
    case (mode_d)
      MODE_LOAD: p_d = load_we ? p_eff + 1'b1 : p_eff;
      MODE_RUN: begin
        if (mode_q != MODE_RUN) begin
          r_d = '0;
        end else begin
          dout_d = rd_byte;
          if (r_q < RD_END) r_d = r_q + 1'b1;
        end
      end
      MODE_RESW: q_d = resw_we ? q_eff + 1'b1 : q_eff;
      default: ;
    endcase
  end

  always_comb begin
    rd_loc  = locate(r_q, RD_C12, RD_C34, RD_C5);
    rd_word = '0;
    rd_byte = end_byte;
    if (r_q < RD_END) begin
      case (rd_loc.rgn)
        RGN_IMG: begin
          rd_word = img_ram[rd_loc.off[IMGW+1:2]];
          case (rd_loc.off[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
          endcase
        end
        RGN_C12: rd_byte = c12_ram[rd_loc.off[C12W-1:0]];
        RGN_C34: rd_byte = c34_ram[rd_loc.off[C34W-1:0]];
        default: rd_byte = c5_ram[rd_loc.off[C5W-1:0]];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_IDLE;
      p_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dout_q <= '0;
    end else begin
      mode_q <= mode_d;
      p_q    <= p_d;
      r_q    <= r_d;
      q_q    <= q_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      case (ld_loc.rgn)
        RGN_IMG: img_ram[ld_loc.off[IMGW-1:0]] <= writedata;
        RGN_C12: c12_ram[ld_loc.off[C12W-1:0]] <= writedata[7:0];
        RGN_C34: c34_ram[ld_loc.off[C34W-1:0]] <= writedata[7:0];
        default: c5_ram[ld_loc.off[C5W-1:0]]   <= writedata[7:0];
      endcase
    end
  end

  npu_res_bank #(.DEPTH(RES_DEPTH), .AW(QW)) res_ram0 (
    .clk(clk), .we_i(resw_we), .addr_i(q_eff), .data_i(writedata[31:24]));
  npu_res_bank #(.DEPTH(RES_DEPTH), .AW(QW)) res_ram1 (
    .clk(clk), .we_i(resw_we), .addr_i(q_eff), .data_i(writedata[23:16]));
  npu_res_bank #(.DEPTH(RES_DEPTH), .AW(QW)) res_ram2 (
    .clk(clk), .we_i(resw_we), .addr_i(q_eff), .data_i(writedata[15:8]));
  npu_res_bank #(.DEPTH(RES_DEPTH), .AW(QW)) res_ram3 (
    .clk(clk), .we_i(resw_we), .addr_i(q_eff), .data_i(writedata[7:0]));

`ifdef STREAM_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  // Running sum of every byte actually written during LOAD; restarts on LOAD entry.
  always_comb begin
    cksum_d = cksum_q;
    if (mode_d == MODE_LOAD) begin
      if (mode_q != MODE_LOAD) cksum_d = '0;
      if (load_we) begin
        cksum_d = cksum_d + ((ld_loc.rgn == RGN_IMG)
                  ? writedata[31:24] + writedata[23:16] + writedata[15:8] + writedata[7:0]
                  : writedata[7:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign end_byte = cksum_q;
`else
  assign end_byte = 8'h00;
`endif
endmodule

// File: tb/tb_npu_mem_top.sv
// Directed bench for npu_mem_top: reset, full LOAD, RUN replay, saturation, IDLE hold, RESW banks.
// The end-of-stream value follows STREAM_CKSUM_EN when the build defines it.

module tb_npu_mem_top;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata;
  logic [31:0] control_reg;
  logic [7:0]  D_OUT;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] exp_sum;
  logic [7:0] exp_end;
  logic [7:0] exp_byte;

  npu_mem_top dut (
    .clk        (clk),
    .reset      (reset),
    .writedata  (writedata),
    .control_reg(control_reg),
    .D_OUT      (D_OUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    control_reg = 32'd2;
    writedata   = '0;
    exp_sum     = '0;
    #1;
    check8("reset_dout", D_OUT, 8'h00);

    // Short LOAD, then reset mid-LOAD: written entries must survive.
    #1;
    reset       = 1'b1;
    control_reg = 32'hFFFF_FFF1;
    writedata   = 32'hCAFE_F00D;
    tick();
    writedata = 32'h1234_5678;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check32("retain_img1", dut.img_ram[1], 32'h1234_5678);
    #1;
    reset = 1'b1;

    // Full LOAD restarting at entry 0.
    for (int k = 0; k < 224; k++) begin
      writedata = {8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3), 8'(4 * k + 4)};
      exp_sum   = exp_sum + writedata[31:24] + writedata[23:16] + writedata[15:8] + writedata[7:0];
      tick();
    end
    for (int i = 0; i < 18816; i++) begin
      writedata = {24'h5A5A5A, 8'(i)};
      exp_sum   = exp_sum + writedata[7:0];
      tick();
    end
    writedata = 32'hFFFF_FFFF;
    repeat (4) tick();

    check32("img0",     dut.img_ram[0],    32'h0102_0304);
    check32("img1",     dut.img_ram[1],    32'h0506_0708);
    check32("img223",   dut.img_ram[223],  32'h7D7E_7F80);
    check8 ("c12_5",    dut.c12_ram[5],    8'h05);
    check8 ("c34_0",    dut.c34_ram[0],    8'h40);
    check8 ("c5_0",     dut.c5_ram[0],     8'h60);
    check8 ("c5_last",  dut.c5_ram[9247],  8'h7F);
    check8 ("c12_0",    dut.c12_ram[0],    8'h00);

    // RUN replay of all 19712 bytes, then the end-of-stream value.
    control_reg = 32'd2;
    tick();
    for (int b = 0; b < 19712; b++) begin
      tick();
      exp_byte = (b < 896) ? 8'(b + 1) : 8'(b - 896);
      check8("stream", D_OUT, exp_byte);
    end
`ifdef STREAM_CKSUM_EN
    exp_end = exp_sum;
`else
    exp_end = 8'h00;
`endif
    tick();
    check8("end_value", D_OUT, exp_end);
    tick();
    check8("end_hold", D_OUT, exp_end);

    control_reg = 32'd0;
    tick();
    tick();
    check8("idle_after_end", D_OUT, exp_end);

    // Re-entering RUN restarts the stream from byte 0.
    control_reg = 32'd2;
    tick();
    tick();
    check8("rerun_b0", D_OUT, 8'h01);
    tick();
    check8("rerun_b1", D_OUT, 8'h02);
    tick();
    check8("rerun_b2", D_OUT, 8'h03);
    control_reg = 32'd0;
    tick();
    tick();
    check8("idle_hold", D_OUT, 8'h03);

    // RESW: first write at Q=0, last at Q=1983, one more ignored.
    control_reg = 32'd3;
    writedata   = 32'hAABB_CCDD;
    tick();
    writedata = 32'h0000_0000;
    repeat (1982) tick();
    writedata = 32'h1122_3344;
    tick();
    writedata = 32'h5566_7788;
    tick();
    check8("res0_0",    dut.res_ram0.mem[0],    8'hAA);
    check8("res3_0",    dut.res_ram3.mem[0],    8'hDD);
    check8("res0_1",    dut.res_ram0.mem[1],    8'h00);
    check8("res2_1983", dut.res_ram2.mem[1983], 8'h33);
    check8("res1_1983", dut.res_ram1.mem[1983], 8'h22);
    check8("res3_1983", dut.res_ram3.mem[1983], 8'h44);
    check8("resw_dout", D_OUT, 8'h03);

    // Asynchronous reset between edges clears D_OUT at once.
    #2;
    reset       = 1'b0;
    control_reg = 32'd2;
    #1;
    check8("async_reset", D_OUT, 8'h00);
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
